top_systolic_array: RTL and testbench

TOP_SYSTOLIC_ARRAY -- requirements
Module: top_systolic_array

---
 rtl/top_systolic_array.sv | 206 ++++++++++++++++++++
 tb/tb_top_systolic_array.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_systolic_array.sv
// ---------------------------------------------------------------------------
// top_systolic_array
//
// Purpose:
//   M_ROWS x N_COLS grid of multiply-accumulate processing elements (PEs).
//   A operands enter on the left edge and shift right one column per feed.
//   B operands enter on the top edge and shift down one row per feed.
//   When both operand streams are fed in the same cycle, every PE adds the
//   product of the operands arriving at it into its accumulator.
//   A small controller streams the accumulators out serially in row-major
//   order.
//
//   All arithmetic is unsigned and wraps modulo 2^DATA_WIDTH.
//
// Parameters:
//   DATA_WIDTH  width of operands, accumulators and stream data
//   RESET_VAL   value loaded into every data register on reset or clear
//   M_ROWS      number of PE rows
//   N_COLS      number of PE columns
//
// Ports:
//   clk_i           single clock, rising edge
//   rst_ni          synchronous reset, active HIGH despite the name
//   array_a_i       A operand per row, array_a_i[r] feeds row r
//   array_b_i       B operand per column, array_b_i[c] feeds column c
//   feed_a_valid_i  shift A operands this cycle
//   feed_b_valid_i  shift B operands this cycle
//   a_clr_i         clear all A registers
//   b_clr_i         clear all B registers
//   acc_clr_i       clear all accumulators
//   start_stream_i  start serial readout of the accumulators
//   stream_clr_i    abort the readout and clear the stream outputs
//   stream_valid_o  stream_data_o holds a valid element
//   stream_data_o   accumulator element being streamed
// ---------------------------------------------------------------------------
module top_systolic_array #(
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
    parameter int                    M_ROWS     = 5,
    parameter int                    N_COLS     = M_ROWS
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [M_ROWS-1:0][DATA_WIDTH-1:0]    array_a_i,
    input  logic [N_COLS-1:0][DATA_WIDTH-1:0]    array_b_i,
    input  logic                                 feed_a_valid_i,
    input  logic                                 feed_b_valid_i,
    input  logic                                 a_clr_i,
    input  logic                                 b_clr_i,
    input  logic                                 acc_clr_i,
    input  logic                                 start_stream_i,
    input  logic                                 stream_clr_i,
    output logic                                 stream_valid_o,
    output logic [DATA_WIDTH-1:0]                stream_data_o
);

    localparam int TOTAL = M_ROWS * N_COLS;
    localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

    localparam logic STATE_IDLE   = 1'b0;
    localparam logic STATE_STREAM = 1'b1;

    // Register views exported by each PE so that neighbours and the
    // stream controller can reach them.
    logic [DATA_WIDTH-1:0] aRegW   [M_ROWS][N_COLS];
    logic [DATA_WIDTH-1:0] bRegW   [M_ROWS][N_COLS];
    logic [DATA_WIDTH-1:0] accFlat [TOTAL];

    // -----------------------------------------------------------------------
    // PE grid
    // -----------------------------------------------------------------------
    for (genvar r = 0; r < M_ROWS; r++) begin : gRow
        for (genvar c = 0; c < N_COLS; c++) begin : gCol
            logic [DATA_WIDTH-1:0] aIn;
            logic [DATA_WIDTH-1:0] bIn;
            logic [DATA_WIDTH-1:0] aReg_q,   aReg_d;
            logic [DATA_WIDTH-1:0] bReg_q,   bReg_d;
            logic [DATA_WIDTH-1:0] accReg_q, accReg_d;

            // Left column takes the external A operand, others take the
            // A register of the PE to the left. No skew is applied.
            if (c == 0) begin : gAEdge
                assign aIn = array_a_i[r];
            end else begin : gAChain
                assign aIn = aRegW[r][c-1];
            end

            // Top row takes the external B operand, others take the
            // B register of the PE above.
            if (r == 0) begin : gBEdge
                assign bIn = array_b_i[c];
            end else begin : gBChain
                assign bIn = bRegW[r-1][c];
            end

            // Clears win over feeding. The accumulator uses the operands
            // arriving this cycle, not the ones already held, and the
            // DATA_WIDTH-wide context makes product and sum wrap.
            always_comb begin
                aReg_d   = aReg_q;
                bReg_d   = bReg_q;
                accReg_d = accReg_q;
                if (a_clr_i) begin
                    aReg_d = RESET_VAL;
                end else if (feed_a_valid_i) begin
                    aReg_d = aIn;
                end
                if (b_clr_i) begin
                    bReg_d = RESET_VAL;
                end else if (feed_b_valid_i) begin
                    bReg_d = bIn;
                end
                if (acc_clr_i) begin
                    accReg_d = RESET_VAL;
                end else if (feed_a_valid_i && feed_b_valid_i) begin
                    accReg_d = accReg_q + aIn * bIn;
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_ni) begin
                    aReg_q   <= RESET_VAL;
                    bReg_q   <= RESET_VAL;
                    accReg_q <= RESET_VAL;
                end else begin
                    aReg_q   <= aReg_d;
                    bReg_q   <= bReg_d;
                    accReg_q <= accReg_d;
                end
            end

            assign aRegW[r][c]          = aReg_q;
            assign bRegW[r][c]          = bReg_q;
            assign accFlat[r*N_COLS+c]  = accReg_q;
        end
    end

    // -----------------------------------------------------------------------
    // Stream controller
    // -----------------------------------------------------------------------
    logic                  state_q,       state_d;
    logic [IDX_W-1:0]      idx_q,         idx_d;
    logic                  streamValid_q, streamValid_d;
    logic [DATA_WIDTH-1:0] streamData_q,  streamData_d;

    // The flat accumulator view is row-major, so the running index maps
    // directly onto it. Accumulators are read live, so feeding during a
    // readout shows up in later elements. After the final element the
    // data register keeps its value and only valid drops.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        streamValid_d = streamValid_q;
        streamData_d  = streamData_q;
        if (stream_clr_i) begin
            state_d       = STATE_IDLE;
            idx_d         = '0;
            streamValid_d = 1'b0;
            streamData_d  = RESET_VAL;
        end else begin
            case (state_q)
                STATE_IDLE: begin
                    streamValid_d = 1'b0;
                    if (start_stream_i) begin
                        state_d = STATE_STREAM;
                        idx_d   = '0;
                    end
                end
                STATE_STREAM: begin
                    streamData_d  = accFlat[idx_q];
                    streamValid_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = STATE_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: begin
                    state_d       = STATE_IDLE;
                    idx_d         = '0;
                    streamValid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            state_q       <= STATE_IDLE;
            idx_q         <= '0;
            streamValid_q <= 1'b0;
            streamData_q  <= RESET_VAL;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            streamValid_q <= streamValid_d;
            streamData_q  <= streamData_d;
        end
    end

    assign stream_valid_o = streamValid_q;
    assign stream_data_o  = streamData_q;

endmodule

// File: tb/tb_top_systolic_array.sv
// ---------------------------------------------------------------------------
// tb_top_systolic_array
//
// Purpose:
//   Self-checking bench for top_systolic_array with default parameters
//   (16-bit data, 5x5 grid, reset value 0). A behavioural model holds the
//   A, B and accumulator grids as plain arrays and updates them from the
//   shifting/MAC rules every clock; streamed elements are compared with it.
//
// Ports: none.
// ---------------------------------------------------------------------------
module tb_top_systolic_array;

    localparam int DW = 16;
    localparam int M  = 5;
    localparam int N  = 5;
    localparam int T  = M * N;

    logic                 clk;
    logic                 rst;
    logic [M-1:0][DW-1:0] aDrv;
    logic [N-1:0][DW-1:0] bDrv;
    logic                 faDrv, fbDrv;
    logic                 aClrDrv, bClrDrv, accClrDrv;
    logic                 startDrv, streamClrDrv;
    logic                 streamValid;
    logic [DW-1:0]        streamData;

    int checkCount = 0;
    int failCount  = 0;

    logic [DW-1:0] ma   [M][N];
    logic [DW-1:0] mb   [M][N];
    logic [DW-1:0] macc [M][N];

    top_systolic_array #(
        .DATA_WIDTH(DW),
        .RESET_VAL (16'h0000),
        .M_ROWS    (M),
        .N_COLS    (N)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst),
        .array_a_i      (aDrv),
        .array_b_i      (bDrv),
        .feed_a_valid_i (faDrv),
        .feed_b_valid_i (fbDrv),
        .a_clr_i        (aClrDrv),
        .b_clr_i        (bClrDrv),
        .acc_clr_i      (accClrDrv),
        .start_stream_i (startDrv),
        .stream_clr_i   (streamClrDrv),
        .stream_valid_o (streamValid),
        .stream_data_o  (streamData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation and count it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Behavioural update of the grids for one clock edge, using the
    // inputs the bench is currently driving.
    task automatic modelStep();
        logic [DW-1:0] na [M][N];
        logic [DW-1:0] nb [M][N];
        logic [DW-1:0] nacc [M][N];
        logic [DW-1:0] ain, bin;
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < N; c++) begin
                if (c == 0) ain = aDrv[r]; else ain = ma[r][c-1];
                if (r == 0) bin = bDrv[c]; else bin = mb[r-1][c];
                na[r][c]   = aClrDrv ? '0 : (faDrv ? ain : ma[r][c]);
                nb[r][c]   = bClrDrv ? '0 : (fbDrv ? bin : mb[r][c]);
                if (accClrDrv)           nacc[r][c] = '0;
                else if (faDrv && fbDrv) nacc[r][c] = DW'((int'(macc[r][c]) + int'(ain) * int'(bin)) % 65536);
                else                     nacc[r][c] = macc[r][c];
                if (rst) begin
                    na[r][c] = '0; nb[r][c] = '0; nacc[r][c] = '0;
                end
            end
        end
        ma = na; mb = nb; macc = nacc;
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic fa, input logic fb, input logic aClr,
                                 input logic bClr, input logic accClr);
        faDrv = fa; fbDrv = fb; aClrDrv = aClr; bClrDrv = bClr; accClrDrv = accClr;
    endtask

    task automatic randomOperands();
        for (int r = 0; r < M; r++) aDrv[r] = DW'($urandom);
        for (int c = 0; c < N; c++) bDrv[c] = DW'($urandom);
    endtask

    // Pulse start and check all elements in row-major order. With liveFeed
    // set, random feeds and stray start pulses are applied mid-stream; each
    // element must reflect the accumulator before that cycle's feed.
    task automatic streamAndCheck(input string tag, input bit liveFeed);
        int validCount = 0;
        logic [DW-1:0] exp = '0;
        applyStimulus(0, 0, 0, 0, 0);
        startDrv = 1'b1;
        tick();
        startDrv = 1'b0;
        for (int k = 0; k < T; k++) begin
            exp = macc[k / N][k % N];
            if (liveFeed) begin
                randomOperands();
                applyStimulus(1'($urandom), 1'($urandom), 0, 0, 0);
                startDrv = 1'($urandom);
            end
            tick();
            if (streamValid) validCount++;
            checkOutput($sformatf("%s valid[%0d]", tag, k), 32'(streamValid), 32'd1);
            checkOutput($sformatf("%s data[%0d]", tag, k), 32'(streamData), 32'(exp));
        end
        applyStimulus(0, 0, 0, 0, 0);
        startDrv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (streamValid) validCount++;
        end
        checkOutput({tag, " valid after"}, 32'(streamValid), 32'd0);
        checkOutput({tag, " data hold"}, 32'(streamData), 32'(exp));
        checkOutput({tag, " valid count"}, 32'(validCount), 32'(T));
    endtask

    initial begin
        aDrv = '0; bDrv = '0;
        applyStimulus(0, 0, 0, 0, 0);
        startDrv = 1'b0; streamClrDrv = 1'b0;
        rst = 1'b1;
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = 16'h1234; mb[r][c] = 16'h1234; macc[r][c] = 16'h1234;
            end
        @(negedge clk);

        // Reset for three cycles while junk is fed: reset must win.
        randomOperands();
        applyStimulus(1, 1, 0, 0, 0);
        startDrv = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checkOutput("reset valid", 32'(streamValid), 32'd0);
        checkOutput("reset data", 32'(streamData), 32'd0);
        rst = 1'b0; startDrv = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        tick();
        checkOutput("post reset valid", 32'(streamValid), 32'd0);
        streamAndCheck("zeros", 0);

        // Single feed: A = 1..5 per row, B = all ones.
        for (int r = 0; r < M; r++) aDrv[r] = DW'(r + 1);
        for (int c = 0; c < N; c++) bDrv[c] = 16'd1;
        applyStimulus(1, 1, 0, 0, 0);
        tick();
        streamAndCheck("single", 0);

        // Five random feed cycles on a cleared array.
        applyStimulus(0, 0, 1, 1, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            randomOperands();
            applyStimulus(1, 1, 0, 0, 0);
            tick();
        end
        streamAndCheck("random5", 0);

        // Wrap-around: 0xFFFF * 2 truncates to 0xFFFE.
        applyStimulus(0, 0, 1, 1, 1);
        tick();
        for (int r = 0; r < M; r++) aDrv[r] = 16'hFFFF;
        for (int c = 0; c < N; c++) bDrv[c] = 16'h0002;
        applyStimulus(1, 1, 0, 0, 0);
        tick();
        streamAndCheck("overflow", 0);

        // Accumulator clear beats a simultaneous feed.
        randomOperands();
        applyStimulus(1, 1, 0, 0, 0);
        tick();
        randomOperands();
        applyStimulus(1, 1, 0, 0, 0);
        tick();
        randomOperands();
        applyStimulus(1, 1, 0, 0, 1);
        tick();
        streamAndCheck("accclr", 0);

        // Build up state, clear only A, stream, then feed to expose A = 0.
        for (int i = 0; i < 3; i++) begin
            randomOperands();
            applyStimulus(1, 1, 0, 0, 0);
            tick();
        end
        applyStimulus(0, 0, 1, 0, 0);
        tick();
        streamAndCheck("aclr acc", 0);
        randomOperands();
        applyStimulus(1, 1, 0, 0, 0);
        tick();
        streamAndCheck("aclr feed", 0);

        // Random mixed feeds/clears, then a stream with live feeding.
        for (int i = 0; i < 20; i++) begin
            randomOperands();
            applyStimulus(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
            tick();
        end
        streamAndCheck("live", 1);

        // Abort at element 3, start held alongside the abort must be ignored.
        applyStimulus(0, 0, 0, 0, 0);
        startDrv = 1'b1;
        tick();
        startDrv = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        checkOutput("abort elem3", 32'(streamData), 32'(macc[3 / N][3 % N]));
        streamClrDrv = 1'b1; startDrv = 1'b1;
        tick();
        checkOutput("abort valid", 32'(streamValid), 32'd0);
        checkOutput("abort data", 32'(streamData), 32'd0);
        streamClrDrv = 1'b0; startDrv = 1'b0;
        tick();
        checkOutput("abort idle", 32'(streamValid), 32'd0);
        streamAndCheck("restart", 0);

        // Reset during a stream aborts it and clears the grid.
        startDrv = 1'b1;
        tick();
        startDrv = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        checkOutput("mid reset valid", 32'(streamValid), 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("mid reset idle", 32'(streamValid), 32'd0);
        streamAndCheck("after reset", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
